main_xfer_seq: RTL and testbench
================================

MAIN_XFER_SEQ -- requirements
Module: main_xfer_seq

Interface
REQ-001 The block SHALL have parameter WIDTH_MAIN, default 8: main bus width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 4: number of register_xfer-style registers on the main bus.
REQ-003 The block SHALL have parameter SEL_W, default 2: register select width, equal to clog2(NUM_REGS).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk, input, 1 bit, rising-edge clock; reset, input, 1 bit, synchronous, active-low.
REQ-005 The block SHALL have input start, 1 bit: active-high request to copy a 16-bit register value over the main bus.
REQ-006 The block SHALL have inputs src_sel and dst_sel, SEL_W bits each: source and destination register indices, sampled when a start is accepted.
REQ-007 The block SHALL have input high_first, 1 bit: 1 moves the high byte first; sampled when a start is accepted.
REQ-008 The block SHALL have input main_en_in, NUM_REGS bits: per-register active-high main bus enables.
REQ-009 The block SHALL have input main_data_in, NUM_REGS*WIDTH_MAIN bits: per-register main outputs; register i occupies bits [i*WIDTH_MAIN +: WIDTH_MAIN].
REQ-010 The block SHALL have outputs assertlow_main, asserthigh_main, loadlow_main and loadhigh_main, NUM_REGS bits each: per-register active-low strobes.
REQ-011 The block SHALL have output main_bus, WIDTH_MAIN bits: resolved main bus value.
REQ-012 The block SHALL have outputs busy, done and err_sel, 1 bit each: busy is a level; done and err_sel are one-cycle pulses.
REQ-013 The block SHALL have output err_contention, 1 bit: sticky flag for a bus drive conflict.

Function
REQ-014 The state machine SHALL have states IDLE, BYTE0, BYTE1 and FIN.
REQ-015 In IDLE, with start=1 and src_sel!=dst_sel, the block SHALL latch src_sel, dst_sel and high_first, and enter BYTE0 on the next edge.
REQ-016 In IDLE, with start=1 and src_sel==dst_sel, the block SHALL pulse err_sel for one cycle, assert no strobe and stay in IDLE.
REQ-017 BYTE0 SHALL go to BYTE1, BYTE1 SHALL go to FIN, and FIN SHALL go to IDLE, each unconditionally after one cycle.
REQ-018 In BYTE0 with high_first=0, assertlow_main[src] and loadlow_main[dst] SHALL be 0; with high_first=1, asserthigh_main[src] and loadhigh_main[dst] SHALL be 0.
REQ-019 BYTE1 SHALL drive the opposite byte pair to BYTE0.
REQ-020 Every strobe bit not named in REQ-018/REQ-019 SHALL be 1; all strobes SHALL be decoded from registered state only, with no glitch on state change.
REQ-021 busy SHALL be 1 in BYTE0, BYTE1 and FIN; done SHALL be 1 only in FIN.
REQ-022 A transfer SHALL take three cycles from the accept edge to done, and the destination SHALL hold the full word at the edge ending BYTE1.
REQ-023 start SHALL be ignored while busy=1; a start in the FIN cycle SHALL be ignored, so back-to-back transfers need start re-sampled in IDLE.
REQ-024 main_bus SHALL be combinational: the data slice of the lowest-indexed register with main_en_in set, or all-zeros when none is set.
REQ-025 err_contention SHALL set when two or more main_en_in bits are 1 in the same cycle, in any state.
REQ-026 err_contention SHALL clear only on reset or on an accepted start.
REQ-027 The block SHALL NOT gate main_en_in; it only observes it.

Reset
REQ-028 When reset=0 at a rising edge, the block SHALL go to IDLE, clear err_contention and clear the latched selects.
REQ-029 From the next cycle after reset, all strobes SHALL be 1, and busy, done and err_sel SHALL be 0.
REQ-030 A reset during BYTE0 or BYTE1 SHALL abort the transfer; a partial destination update is allowed and no done is issued.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, BYTE0, BYTE1, FIN) and the default WIDTH_MAIN/NUM_REGS constants.
REQ-032 One sub-module, main_bus_resolve, SHALL hold the priority mux and contention detect as purely combinational logic.
REQ-033 The FSM and strobe decode SHALL stay in main_xfer_seq.

Verification
REQ-034 With reg1=16'hBEEF, a pulse start src=1 dst=2 high_first=0 SHALL give: BYTE0 main_bus=8'hEF with loadlow_main[2]=0, BYTE1 8'hBE, done in cycle 3, and reg2=16'hBEEF.
REQ-035 The same transfer with high_first=1 SHALL drive 8'hBE then 8'hEF and give reg2=16'hBEEF.
REQ-036 start src=3 dst=3 SHALL give one err_sel pulse, all strobes 1, and busy=0 throughout.
REQ-037 Forcing main_en_in=4'b0101 for one cycle SHALL give err_contention=1 and main_bus=reg0 data; err_contention SHALL hold until the next accepted start, then read 0.
REQ-038 Driving reset=0 during BYTE1 SHALL give all strobes 1 on the next cycle, state IDLE, no done, and no reaction to a start held during reset.
REQ-039 start held high for 6 cycles SHALL run exactly two transfers, with accepts 4 cycles apart.

Source files
------------

// File: rtl/main_xfer_seq_pkg.sv
// Shared types and default sizes for the main bus transfer sequencer.
// Holds the FSM state encoding used by the sequencer and its bench.
package main_xfer_seq_pkg;

    localparam int WIDTH_MAIN_DEF = 8;
    localparam int NUM_REGS_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        FIN   = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/main_xfer_seq_if.sv
// Main bus transfer interface: request, register bank strobes, bus, status.
// master = requester / register bank side, slave = sequencer side.
interface main_xfer_seq_if
    import main_xfer_seq_pkg::*;
#(
    parameter int WIDTH_MAIN = WIDTH_MAIN_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int SEL_W      = 2
);

    logic                           start;
    logic [SEL_W-1:0]               src_sel;
    logic [SEL_W-1:0]               dst_sel;
    logic                           high_first;
    logic [NUM_REGS-1:0]            main_en_in;
    logic [NUM_REGS*WIDTH_MAIN-1:0] main_data_in;
    logic [NUM_REGS-1:0]            assertlow_main;
    logic [NUM_REGS-1:0]            asserthigh_main;
    logic [NUM_REGS-1:0]            loadlow_main;
    logic [NUM_REGS-1:0]            loadhigh_main;
    logic [WIDTH_MAIN-1:0]          main_bus;
    logic                           busy;
    logic                           done;
    logic                           err_sel;
    logic                           err_contention;

    modport master (
        output start, src_sel, dst_sel, high_first,
        output main_en_in, main_data_in,
        input  assertlow_main, asserthigh_main,
        input  loadlow_main, loadhigh_main,
        input  main_bus, busy, done, err_sel, err_contention
    );

    modport slave (
        input  start, src_sel, dst_sel, high_first,
        input  main_en_in, main_data_in,
        output assertlow_main, asserthigh_main,
        output loadlow_main, loadhigh_main,
        output main_bus, busy, done, err_sel, err_contention
    );

endinterface

// File: rtl/main_xfer_seq_bus_resolve.sv
// Priority resolution of the shared main bus plus multi-driver detect.
// Lowest-indexed enabled register wins; no enable gives all zeros.
module main_bus_resolve #(
    parameter int WIDTH_MAIN = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic [NUM_REGS-1:0]            en_i,
    input  logic [NUM_REGS*WIDTH_MAIN-1:0] data_i,
    output logic [WIDTH_MAIN-1:0]          bus_o,
    output logic                           multi_o
);

    logic found;

    // Scan upward: first enable selects data, any later one flags a conflict
    always_comb begin
        bus_o   = '0;
        multi_o = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i[i]) begin
                if (found) begin
                    multi_o = 1'b1;
                end else begin
                    bus_o = data_i[i*WIDTH_MAIN +: WIDTH_MAIN];
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/main_xfer_seq.sv
// Sequences a 16-bit register-to-register copy as two main bus bytes.
// Strobes and status are registered from the next state, so they never glitch.
module main_xfer_seq
    import main_xfer_seq_pkg::*;
#(
    parameter int WIDTH_MAIN = WIDTH_MAIN_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int SEL_W      = 2
) (
    input  logic           clk,
    input  logic           reset,
    main_xfer_seq_if.slave xfer
);

    xfer_state_e         state_q, state_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic                hf_q, hf_d;
    logic [NUM_REGS-1:0] al_q, al_d;
    logic [NUM_REGS-1:0] ah_q, ah_d;
    logic [NUM_REGS-1:0] ll_q, ll_d;
    logic [NUM_REGS-1:0] lh_q, lh_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                esel_q, esel_d;
    logic                cont_q, cont_d;
    logic                accept;
    logic [NUM_REGS-1:0] src_oh;
    logic [NUM_REGS-1:0] dst_oh;
    logic                low_phase;
    logic [WIDTH_MAIN-1:0] bus_w;
    logic                multi_w;

    main_bus_resolve #(
        .WIDTH_MAIN (WIDTH_MAIN),
        .NUM_REGS   (NUM_REGS)
    ) u_resolve (
        .en_i    (xfer.main_en_in),
        .data_i  (xfer.main_data_in),
        .bus_o   (bus_w),
        .multi_o (multi_w)
    );

    // Next state, latched selects and the strobe pattern for that state
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        hf_d      = hf_q;
        accept    = 1'b0;
        esel_d    = 1'b0;
        src_oh    = '0;
        dst_oh    = '0;
        low_phase = 1'b0;
        al_d      = '1;
        ah_d      = '1;
        ll_d      = '1;
        lh_d      = '1;
        unique case (state_q)
            IDLE: begin
                if (xfer.start) begin
                    if (xfer.src_sel != xfer.dst_sel) begin
                        accept  = 1'b1;
                        src_d   = xfer.src_sel;
                        dst_d   = xfer.dst_sel;
                        hf_d    = xfer.high_first;
                        state_d = BYTE0;
                    end else begin
                        esel_d  = 1'b1;
                    end
                end
            end
            BYTE0: state_d = BYTE1;
            BYTE1: state_d = FIN;
            FIN:   state_d = IDLE;
        endcase
        src_oh[src_d] = 1'b1;
        dst_oh[dst_d] = 1'b1;
        low_phase = (state_d == BYTE0) ? !hf_d : hf_d;
        if (state_d == BYTE0 || state_d == BYTE1) begin
            if (low_phase) begin
                al_d = ~src_oh;
                ll_d = ~dst_oh;
            end else begin
                ah_d = ~src_oh;
                lh_d = ~dst_oh;
            end
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        cont_d = multi_w | (cont_q & ~accept);
    end

    // Sequencer state and every registered output
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            hf_q    <= 1'b0;
            al_q    <= '1;
            ah_q    <= '1;
            ll_q    <= '1;
            lh_q    <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            esel_q  <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            hf_q    <= hf_d;
            al_q    <= al_d;
            ah_q    <= ah_d;
            ll_q    <= ll_d;
            lh_q    <= lh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            esel_q  <= esel_d;
            cont_q  <= cont_d;
        end
    end

    assign xfer.assertlow_main  = al_q;
    assign xfer.asserthigh_main = ah_q;
    assign xfer.loadlow_main    = ll_q;
    assign xfer.loadhigh_main   = lh_q;
    assign xfer.main_bus        = bus_w;
    assign xfer.busy            = busy_q;
    assign xfer.done            = done_q;
    assign xfer.err_sel         = esel_q;
    assign xfer.err_contention  = cont_q;

endmodule

// File: tb/tb_main_xfer_seq.sv
// Bench for main_xfer_seq with a small 16-bit register bank on the bus.
// Table vectors, hand sequences for corner cases, then random transfers.
module tb_main_xfer_seq;

    logic clk;
    logic reset;

    main_xfer_seq_if #(.WIDTH_MAIN(8), .NUM_REGS(4), .SEL_W(2)) bus ();

    main_xfer_seq #(.WIDTH_MAIN(8), .NUM_REGS(4), .SEL_W(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .xfer  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] regs [4];
    logic [15:0] model_regs [4];
    logic        pre_we;
    logic [1:0]  pre_idx;
    logic [15:0] pre_val;
    logic        force_en;
    logic [3:0]  force_val;
    logic [3:0]  en;
    logic [31:0] dat;
    logic [15:0] strb;

    int n_checks;
    int n_errors;

    assign strb = {bus.assertlow_main, bus.asserthigh_main,
                   bus.loadlow_main, bus.loadhigh_main};

    // Register bank drives the selected byte when its assert strobe is low
    always_comb begin
        en  = '0;
        dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (!bus.assertlow_main[i]) begin
                en[i] = 1'b1;
                dat[i*8 +: 8] = regs[i][7:0];
            end else if (!bus.asserthigh_main[i]) begin
                en[i] = 1'b1;
                dat[i*8 +: 8] = regs[i][15:8];
            end else begin
                dat[i*8 +: 8] = regs[i][7:0];
            end
        end
        if (force_en) en = force_val;
    end

    assign bus.main_en_in   = en;
    assign bus.main_data_in = dat;

    // Register bank captures the bus on its load strobes
    always @(posedge clk) begin
        if (pre_we) begin
            regs[pre_idx] <= pre_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.loadlow_main[i])  regs[i][7:0]  <= bus.main_bus;
                if (!bus.loadhigh_main[i]) regs[i][15:8] <= bus.main_bus;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic preload(input logic [1:0] i, input logic [15:0] v);
        pre_we  = 1'b1;
        pre_idx = i;
        pre_val = v;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Issue one start pulse and check every cycle of the expected outcome
    task automatic do_xfer(input logic [1:0] s, input logic [1:0] d,
                           input logic hf, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [15:0] wdst,
                           input logic is_err);
        logic [15:0] st0, st1;
        st0 = hf ? {4'hF, ~oh(s), 4'hF, ~oh(d)} : {~oh(s), 4'hF, ~oh(d), 4'hF};
        st1 = hf ? {~oh(s), 4'hF, ~oh(d), 4'hF} : {4'hF, ~oh(s), 4'hF, ~oh(d)};
        bus.start      = 1'b1;
        bus.src_sel    = s;
        bus.dst_sel    = d;
        bus.high_first = hf;
        @(negedge clk);
        bus.start = 1'b0;
        if (is_err) begin
            check("err_sel pulse", 32'(bus.err_sel), 32'd1);
            check("err busy", 32'(bus.busy), 32'd0);
            check("err strobes", 32'(strb), 32'hFFFF);
            @(negedge clk);
            check("err_sel clear", 32'(bus.err_sel), 32'd0);
            check("err busy2", 32'(bus.busy), 32'd0);
            check("err strobes2", 32'(strb), 32'hFFFF);
        end else begin
            check("b0 busy", 32'(bus.busy), 32'd1);
            check("b0 bus", 32'(bus.main_bus), 32'(b0));
            check("b0 strobes", 32'(strb), 32'(st0));
            check("b0 done", 32'(bus.done), 32'd0);
            check("b0 cont", 32'(bus.err_contention), 32'd0);
            @(negedge clk);
            check("b1 bus", 32'(bus.main_bus), 32'(b1));
            check("b1 strobes", 32'(strb), 32'(st1));
            check("b1 done", 32'(bus.done), 32'd0);
            @(negedge clk);
            check("fin done", 32'(bus.done), 32'd1);
            check("fin busy", 32'(bus.busy), 32'd1);
            check("fin strobes", 32'(strb), 32'hFFFF);
            @(negedge clk);
            check("idle done", 32'(bus.done), 32'd0);
            check("idle busy", 32'(bus.busy), 32'd0);
        end
        check("dst word", 32'(regs[d]), 32'(wdst));
    endtask

    typedef struct {
        logic [1:0]  s;
        logic [1:0]  d;
        logic        hf;
        logic [15:0] src_val;
        logic        err;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] dst;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int rises;
        int first_rise;
        int second_rise;
        int dones;
        logic prev_busy;
        logic [1:0] s;
        logic [1:0] d;
        logic hf;
        logic [15:0] w;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        pre_we = 1'b0;
        pre_idx = '0;
        pre_val = '0;
        force_en = 1'b0;
        force_val = '0;
        bus.start = 1'b0;
        bus.src_sel = '0;
        bus.dst_sel = '0;
        bus.high_first = 1'b0;

        vecs[0] = '{2'd1, 2'd2, 1'b0, 16'hBEEF, 1'b0, 8'hEF, 8'hBE, 16'hBEEF};
        vecs[1] = '{2'd1, 2'd2, 1'b1, 16'hBEEF, 1'b0, 8'hBE, 8'hEF, 16'hBEEF};
        vecs[2] = '{2'd3, 2'd3, 1'b0, 16'h1234, 1'b1, 8'h00, 8'h00, 16'h1234};
        vecs[3] = '{2'd0, 2'd3, 1'b0, 16'hA55A, 1'b0, 8'h5A, 8'hA5, 16'hA55A};
        vecs[4] = '{2'd3, 2'd0, 1'b1, 16'h00FF, 1'b0, 8'h00, 8'hFF, 16'h00FF};
        vecs[5] = '{2'd2, 2'd1, 1'b0, 16'hFF00, 1'b0, 8'h00, 8'hFF, 16'hFF00};

        repeat (3) @(negedge clk);
        check("rst strobes", 32'(strb), 32'hFFFF);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst err_sel", 32'(bus.err_sel), 32'd0);
        check("rst cont", 32'(bus.err_contention), 32'd0);
        check("rst bus", 32'(bus.main_bus), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post rst busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            preload(vecs[i].s, vecs[i].src_val);
            do_xfer(vecs[i].s, vecs[i].d, vecs[i].hf, vecs[i].b0,
                    vecs[i].b1, vecs[i].dst, vecs[i].err);
        end

        preload(2'd0, 16'h3C77);
        preload(2'd3, 16'h1234);
        force_val = 4'b0101;
        force_en = 1'b1;
        #1;
        check("cont bus", 32'(bus.main_bus), 32'h77);
        check("cont pre", 32'(bus.err_contention), 32'd0);
        @(negedge clk);
        force_en = 1'b0;
        check("cont set", 32'(bus.err_contention), 32'd1);
        @(negedge clk);
        check("cont hold", 32'(bus.err_contention), 32'd1);
        do_xfer(2'd3, 2'd3, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b1);
        check("cont after err_sel", 32'(bus.err_contention), 32'd1);
        do_xfer(2'd0, 2'd1, 1'b0, 8'h77, 8'h3C, 16'h3C77, 1'b0);

        preload(2'd0, 16'hCAFE);
        bus.start = 1'b1;
        bus.src_sel = 2'd0;
        bus.dst_sel = 2'd1;
        bus.high_first = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("abort in byte1", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        bus.start = 1'b1;
        bus.src_sel = 2'd2;
        bus.dst_sel = 2'd3;
        @(negedge clk);
        check("abort strobes", 32'(strb), 32'hFFFF);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("abort hold busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort no done", 32'(bus.done), 32'd0);
        check("abort idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("abort no done2", 32'(bus.done), 32'd0);

        rises = 0;
        first_rise = -1;
        second_rise = -1;
        dones = 0;
        prev_busy = 1'b0;
        bus.start = 1'b1;
        bus.src_sel = 2'd2;
        bus.dst_sel = 2'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.busy && !prev_busy) begin
                rises++;
                if (first_rise < 0) first_rise = k;
                else if (second_rise < 0) second_rise = k;
            end
            if (bus.done) dones++;
            prev_busy = bus.busy;
            if (k == 5) bus.start = 1'b0;
        end
        check("held start accepts", 32'(rises), 32'd2);
        check("held start spacing", 32'(second_rise - first_rise), 32'd4);
        check("held start dones", 32'(dones), 32'd2);

        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            model_regs[i] = w;
            preload(2'(i), w);
        end
        for (int it = 0; it < 40; it++) begin
            s  = 2'($urandom_range(0, 3));
            d  = 2'($urandom_range(0, 3));
            hf = 1'($urandom_range(0, 1));
            w  = model_regs[s];
            if (s != d) model_regs[d] = w;
            do_xfer(s, d, hf, hf ? w[15:8] : w[7:0], hf ? w[7:0] : w[15:8],
                    model_regs[d], s == d);
            for (int i = 0; i < 4; i++)
                check("rand bank", 32'(regs[i]), 32'(model_regs[i]));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
